// File: rtl/and_reduce_tree_pipe.sv
// ============================================================================
// and_reduce_tree_pipe : pipelined FANIN-ary AND/OR reduction tree with
// valid/ready handshake and global stall. Option: AND_TREE_TOGGLE_CNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module and_reduce_tree_pipe #(
  parameter int WIDTH = 4,
  parameter int FANIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic             out_mode
`ifdef AND_TREE_TOGGLE_CNT_EN
  ,
  output logic [15:0]      toggle_cnt
`endif
);

  function automatic int nodes_at(int lvl);
    int n;
    n = WIDTH;
    for (int i = 0; i < lvl; i++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction

  function automatic int calc_levels();
    int n;
    int l;
    n = (WIDTH + FANIN - 1) / FANIN;
    l = 1;
    while (n > 1) begin
      n = (n + FANIN - 1) / FANIN;
      l++;
    end
    return l;
  endfunction

  // Bit offset of stage s inside the flattened data register.
  function automatic int stage_off(int s);
    int o;
    o = 0;
    for (int t = 0; t < s; t++) o += nodes_at(t + 1);
    return o;
  endfunction

  localparam int LEVELS = calc_levels();
  localparam int TOTAL  = stage_off(LEVELS);

  logic [LEVELS-1:0] valid_q, valid_d;
  logic [LEVELS-1:0] mode_q, mode_d;
  logic [TOTAL-1:0]  data_q, data_d;
  wire  [TOTAL-1:0]  reduced;
  logic              stall;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q[LEVELS-1];
  assign out_mode  = mode_q[LEVELS-1];
  assign out_data  = data_q[TOTAL-1];

  for (genvar s = 0; s < LEVELS; s++) begin : g_level
    localparam int N_IN    = nodes_at(s);
    localparam int N_OUT   = nodes_at(s + 1);
    localparam int OFF_IN  = (s == 0) ? 0 : stage_off(s - 1);
    localparam int OFF_OUT = stage_off(s);

    logic [N_IN-1:0]        src;
    logic                   src_mode;
    logic [N_OUT*FANIN-1:0] padded;
    logic [N_OUT-1:0]       node;

    if (s == 0) begin : g_leaf
      assign src      = in_data;
      assign src_mode = in_mode;
    end else begin : g_inner
      assign src      = data_q[OFF_IN +: N_IN];
      assign src_mode = mode_q[s-1];
    end

    // Missing children take the identity of this vector's own operator.
    always_comb begin
      padded           = {(N_OUT*FANIN){~src_mode}};
      padded[N_IN-1:0] = src;
      node             = '0;
      for (int j = 0; j < N_OUT; j++) begin
        node[j] = src_mode ? (|padded[j*FANIN +: FANIN]) : (&padded[j*FANIN +: FANIN]);
      end
    end

    assign reduced[OFF_OUT +: N_OUT] = node;
  end

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (!stall) begin
      data_d     = reduced;
      valid_d[0] = in_valid;
      mode_d[0]  = in_mode;
      for (int s = 1; s < LEVELS; s++) begin
        valid_d[s] = valid_q[s-1];
        mode_d[s]  = mode_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      mode_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

`ifdef AND_TREE_TOGGLE_CNT_EN
  logic        last_out_q, last_out_d;
  logic [15:0] toggle_cnt_q, toggle_cnt_d;

  always_comb begin
    last_out_d   = last_out_q;
    toggle_cnt_d = toggle_cnt_q;
    if (out_valid && out_ready) begin
      last_out_d = out_data;
      if ((out_data != last_out_q) && (toggle_cnt_q != 16'hFFFF)) begin
        toggle_cnt_d = toggle_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_out_q   <= 1'b0;
      toggle_cnt_q <= 16'd0;
    end else begin
      last_out_q   <= last_out_d;
      toggle_cnt_q <= toggle_cnt_d;
    end
  end

  assign toggle_cnt = toggle_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_and_reduce_tree_pipe.sv
// ============================================================================
// tb_and_reduce_tree_pipe : scoreboard bench for two tree configurations
// (WIDTH=4/FANIN=2 and WIDTH=5/FANIN=2). Rev 1.0
// ============================================================================
`default_nettype none

module tb_and_reduce_tree_pipe;

  localparam int WA = 4;
  localparam int FA = 2;
  localparam int LA = 2;
  localparam int WB = 5;
  localparam int FB = 2;
  localparam int LB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_iv, a_ir, a_im, a_ov, a_or, a_od, a_om;
  logic [WA-1:0] a_id;
  logic          b_iv, b_ir, b_im, b_ov, b_or, b_od, b_om;
  logic [WB-1:0] b_id;
  logic [15:0]   a_tcv, b_tcv;

`ifdef AND_TREE_TOGGLE_CNT_EN
  logic [15:0] a_tc, b_tc;
  assign a_tcv = a_tc;
  assign b_tcv = b_tc;
`else
  assign a_tcv = 16'h0;
  assign b_tcv = 16'h0;
`endif

  and_reduce_tree_pipe #(.WIDTH(WA), .FANIN(FA)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_mode(a_im),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_mode(a_om)
`ifdef AND_TREE_TOGGLE_CNT_EN
    , .toggle_cnt(a_tc)
`endif
  );

  and_reduce_tree_pipe #(.WIDTH(WB), .FANIN(FB)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_mode(b_im),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_mode(b_om)
`ifdef AND_TREE_TOGGLE_CNT_EN
    , .toggle_cnt(b_tc)
`endif
  );

  typedef struct packed {
    logic d;
    logic m;
    int   c0;
    int   s0;
  } exp_t;

  exp_t        q [2][$];
  int          stalls [2];
  logic [15:0] tc_exp [2];
  logic        last_exp [2];
  int          cyc = 0;
  int          vec = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int id, input string nm, input logic [15:0] act, input logic [15:0] expv);
    vec++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, id, act, expv, $time);
    end
  endtask

  // Scoreboard/monitor. Called at the falling edge: all values seen here are
  // the ones the next rising edge (number n) will act on.
  task automatic mon(input int id, input logic ov, input logic ir, input logic od,
                     input logic om, input logic ordy, input logic iv,
                     input logic [7:0] d, input logic m, input int wid,
                     input int lv, input logic [15:0] tc);
    exp_t       e;
    exp_t       ne;
    bit         ev;
    bit         eir;
    int         n;
    logic [7:0] mask;
    n = cyc + 1;
    if (rst) begin
      q[id].delete();
      tc_exp[id]   = 16'd0;
      last_exp[id] = 1'b0;
      chk(id, "reset_out_valid", 16'(ov), 16'd0);
      chk(id, "reset_out_data", 16'(od), 16'd0);
      chk(id, "reset_out_mode", 16'(om), 16'd0);
`ifdef AND_TREE_TOGGLE_CNT_EN
      chk(id, "reset_toggle_cnt", tc, 16'd0);
`endif
      return;
    end
    ev = 1'b0;
    e  = '0;
    if (q[id].size() > 0) begin
      e  = q[id][0];
      ev = ((n - e.c0 - (stalls[id] - e.s0)) >= lv);
    end
    eir = !(ev && !ordy);
    chk(id, "out_valid", 16'(ov), 16'(ev));
    chk(id, "in_ready", 16'(ir), 16'(eir));
`ifdef AND_TREE_TOGGLE_CNT_EN
    chk(id, "toggle_cnt", tc, tc_exp[id]);
`endif
    if (ev) begin
      chk(id, "out_data", 16'(od), 16'(e.d));
      chk(id, "out_mode", 16'(om), 16'(e.m));
      if (ordy) begin
        void'(q[id].pop_front());
        if ((e.d != last_exp[id]) && (tc_exp[id] != 16'hFFFF)) tc_exp[id] = tc_exp[id] + 16'd1;
        last_exp[id] = e.d;
      end else begin
        stalls[id]++;
      end
    end
    if (iv && eir) begin
      mask  = 8'((1 << wid) - 1);
      ne.m  = m;
      ne.d  = m ? (|(d & mask)) : (&(d | ~mask));
      ne.c0 = n;
      ne.s0 = stalls[id];
      q[id].push_back(ne);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_ov, a_ir, a_od, a_om, a_or, a_iv, {4'b0, a_id}, a_im, WA, LA, a_tcv);
    mon(1, b_ov, b_ir, b_od, b_om, b_or, b_iv, {3'b0, b_id}, b_im, WB, LB, b_tcv);
  end

  // ---------------- stimulus ----------------
  bit            pa, pb;
  logic [WA-1:0] da;
  logic [WB-1:0] db;
  logic          ma, mb;

  task automatic set_a(input bit v, input logic [WA-1:0] d, input bit m, input bit r);
    a_iv = v; a_id = d; a_im = m; a_or = r;
  endtask

  task automatic set_b(input bit v, input logic [WB-1:0] d, input bit m, input bit r);
    b_iv = v; b_id = d; b_im = m; b_or = r;
  endtask

  task automatic tick(output bit acc_a, output bit acc_b);
    @(negedge clk);
    acc_a = a_iv & a_ir;
    acc_b = b_iv & b_ir;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_vec(input int w);
    logic [7:0] mask;
    logic [7:0] v;
    mask = 8'((1 << w) - 1);
    case ($urandom_range(0, 4))
      0: v = mask;
      1: v = 8'h00;
      2: v = mask & ~(8'd1 << $urandom_range(0, w - 1));
      3: v = 8'd1 << $urandom_range(0, w - 1);
      default: v = 8'($urandom) & mask;
    endcase
    return v;
  endfunction

  // rmode for dut A: 0 random ready, 1 always ready, 2 never ready.
  task automatic run(input int cycles, input int rmode);
    bit         acca, accb, ra;
    logic [7:0] v;
    for (int c = 0; c < cycles; c++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1'b1; v = rnd_vec(WA); da = v[WA-1:0]; ma = 1'($urandom);
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1'b1; v = rnd_vec(WB); db = v[WB-1:0]; mb = 1'($urandom);
      end
      ra = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      set_a(pa, da, ma, ra);
      set_b(pb, db, mb, $urandom_range(0, 3) != 0);
      tick(acca, accb);
      if (acca) pa = 1'b0;
      if (accb) pb = 1'b0;
    end
  endtask

  task automatic drain();
    bit acca, accb;
    int k;
    pa = 1'b0; pb = 1'b0;
    set_a(1'b0, '0, 1'b0, 1'b1);
    set_b(1'b0, '0, 1'b0, 1'b1);
    k = 0;
    while ((q[0].size() + q[1].size()) != 0 && k < 60) begin
      tick(acca, accb);
      k++;
    end
    tick(acca, accb);
    chk(0, "drain_leftover", 16'(q[0].size() + q[1].size()), 16'd0);
  endtask

  task automatic send_a(input logic [WA-1:0] d, input bit m);
    bit acca, accb;
    int k;
    k = 0;
    set_a(1'b1, d, m, 1'b1);
    do begin
      tick(acca, accb);
      k++;
    end while (!acca && k < 20);
    if (!acca) chk(0, "send_a_timeout", 16'd0, 16'd1);
    set_a(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic send_b(input logic [WB-1:0] d, input bit m);
    bit acca, accb;
    int k;
    k = 0;
    set_b(1'b1, d, m, 1'b1);
    do begin
      tick(acca, accb);
      k++;
    end while (!accb && k < 20);
    if (!accb) chk(1, "send_b_timeout", 16'd0, 16'd1);
    set_b(1'b0, '0, 1'b0, 1'b1);
  endtask

  logic [WA-1:0] sa_d [5];
  bit            sa_m [5];

  initial begin
    bit acca, accb;
    rst = 1'b1;
    pa = 1'b0; pb = 1'b0;
    set_a(1'b0, '0, 1'b0, 1'b1);
    set_b(1'b0, '0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single vector through the width-4 tree.
    send_a(4'b1111, 1'b0);
    repeat (4) tick(acca, accb);

    // Back-to-back mixed-mode stream.
    sa_d = '{4'b1111, 4'b0111, 4'b1111, 4'b0000, 4'b0010};
    sa_m = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      set_a(1'b1, sa_d[i], sa_m[i], 1'b1);
      tick(acca, accb);
    end
    drain();

    // Padding on the width-5 tree.
    send_b(5'b11111, 1'b0);
    send_b(5'b00000, 1'b1);
    send_b(5'b10000, 1'b1);
    send_b(5'b01111, 1'b0);
    drain();

    // Back-pressure: fill, hold ready low, then release.
    run(8, 2);
    run(30, 1);
    drain();

    // Reset with two vectors in flight.
    set_a(1'b1, 4'b1111, 1'b0, 1'b1);
    tick(acca, accb);
    set_a(1'b1, 4'b0000, 1'b1, 1'b1);
    tick(acca, accb);
    set_a(1'b0, '0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk(0, "async_rst_out_valid", 16'(a_ov), 16'd0);
    chk(0, "async_rst_out_data", 16'(a_od), 16'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) tick(acca, accb);
    send_a(4'b1111, 1'b0);
    drain();

    // Random traffic on both trees.
    run(500, 0);
    drain();

`ifdef AND_TREE_TOGGLE_CNT_EN
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_a(4'b1111, 1'b0);
    send_a(4'b1111, 1'b0);
    send_a(4'b0000, 1'b0);
    send_a(4'b1111, 1'b0);
    drain();
    @(negedge clk);
    chk(0, "toggle_cnt_1101", a_tcv, 16'd3);
    @(posedge clk);
    #1;
    for (int i = 0; i < 70000; i++) begin
      set_a(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b1111, 1'b0, 1'b1);
      tick(acca, accb);
    end
    drain();
    @(negedge clk);
    chk(0, "toggle_cnt_sat", a_tcv, 16'hFFFF);
    @(posedge clk);
    #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

`default_nettype wire
